mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 6, instruction opcode field width.
REQ-002 SHALL have parameter FUNCT_WIDTH, default 6, R-type funct field width.
REQ-003 SHALL have parameter ALU_CONTROL, default 4, ALU control code width.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, maximum wait cycles on i_mem_ready before fault.
REQ-005 SHALL have ports: i_clk input 1 clock; rst input 1 async active-high reset; enable input 1 global advance enable; i_opcode input OPCODE_WIDTH instruction opcode; i_funct input FUNCT_WIDTH funct; i_zero input 1 ALU zero flag; i_mem_ready input 1 memory access complete.
REQ-006 SHALL have outputs, each 1 bit unless stated: pc_write; ir_write; i_or_d (1=data address); MemRd; MemWr; MemReg; RegDst; RegWr; alu_src_a; alu_src_b 2; o_alu_control ALU_CONTROL; pc_src 2 (0 ALU, 1 ALUOut, 2 jump); instr_done; illegal; fault; o_state 4.
REQ-007 SHALL use one clock, i_clk; reset rst is asynchronous and active-high.

Function
REQ-008 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP, FAULT; o_state shows current encoding.
REQ-009 SHALL hold state and drive all strobes (pc_write, ir_write, MemRd, MemWr, RegWr) low in any cycle with enable=0.
REQ-010 FETCH: MemRd=1, i_or_d=0; stays until i_mem_ready=1, then ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=1 (PC+4), ADD, pc_src=0, next DECODE.
REQ-011 DECODE: alu_src_a=0, alu_src_b=3 (branch offset), ADD; next by opcode: 100011/101011 MEMADR, 000000 EXEC, 000100/000101 BRANCH, 001000 ADDIEXEC, 000010 JUMP, other FAULT with illegal=1.
REQ-012 MEMADR: alu_src_a=1, alu_src_b=2, ADD; next MEMRD for LW, MEMWR for SW.
REQ-013 MEMRD: MemRd=1, i_or_d=1; waits for i_mem_ready, then MEMWB.
REQ-014 MEMWB: RegDst=0, MemReg=1, RegWr=1 for one cycle; next FETCH, instr_done=1.
REQ-015 MEMWR: MemWr=1, i_or_d=1; waits for i_mem_ready, then FETCH with instr_done=1.
REQ-016 EXEC: alu_src_a=1, alu_src_b=0; o_alu_control from funct: 100000 ADD 0010, 100010 SUB 0110, 100100 AND 0000, 100101 OR 0001, 101010 SLT 0111; unknown funct -> FAULT, illegal=1.
REQ-017 ALUWB: RegDst=1, MemReg=0, RegWr=1; next FETCH, instr_done=1.
REQ-018 BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_write=1 iff (BEQ and i_zero) or (BNE and not i_zero); next FETCH, instr_done=1.
REQ-019 ADDIEXEC: alu_src_a=1, alu_src_b=2, ADD; ADDIWB: RegDst=0, MemReg=0, RegWr=1, then FETCH, instr_done=1.
REQ-020 JUMP: pc_src=2, pc_write=1; next FETCH, instr_done=1.
REQ-021 SHALL count wait cycles in any memory-wait state; counter clears on state entry; reaching MEM_TIMEOUT without i_mem_ready -> FAULT, fault=1.
REQ-022 FAULT: all strobes low, illegal/fault sticky, remains until reset.
REQ-023 instr_done SHALL be a single-cycle pulse, asserted with the final-state transition only.
REQ-024 Opcode/funct SHALL be sampled from instruction register outputs valid from DECODE onward; FSM does not latch them.
REQ-025 i_mem_ready high in same cycle as enable=0 SHALL be ignored; access completes on next enabled ready.

Reset
REQ-026 rst=1 SHALL immediately force FETCH, clear wait counter, illegal=0, fault=0, all strobes 0, o_alu_control=0010, pc_src=0.
REQ-027 Reset mid-access SHALL abort the access with no RegWr/MemWr/pc_write pulse after release.

Structure
REQ-028 Shared package SHALL hold state encodings, opcode constants, funct constants, ALU control codes.
REQ-029 One sub-module alu_decoder (funct -> o_alu_control, valid flag) is natural.

Verification
REQ-030 R-type ADD, mem_ready=1 first cycle: FETCH,DECODE,EXEC,ALUWB; RegWr on cycle 4, instr_done cycle 4, o_alu_control=0010 in EXEC.
REQ-031 LW with mem_ready delayed 3 cycles in MEMRD: 5 states plus 3 stall cycles, RegWr with MemReg=1 once.
REQ-032 BEQ i_zero=1 -> pc_write in BRANCH; BNE i_zero=1 -> no pc_write; both instr_done=1.
REQ-033 opcode 111111 -> FAULT after DECODE, illegal=1 held; mem_ready held low 15 cycles in FETCH -> fault=1.
REQ-034 rst pulse during MEMWR -> FETCH next edge, no MemWr afterwards; enable=0 for 4 cycles in EXEC -> state frozen, no strobes.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// mc_control_fsm_pkg
// Shared definitions for the multi-cycle control FSM:
//   - state_t  : FSM state encoding (also driven out on o_state)
//   - OP_*     : instruction opcode constants
//   - FN_*     : R-type funct constants
//   - ALU_*    : ALU control codes
//   - ctrl_t   : per-state control vector, built by ctrl_for()
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXEC     = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11,
        FAULT    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRC_B_REG    = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_OFFSET = 2'd3;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // Moore part of the control outputs. fetch/jump/branch/final_st are
    // qualifiers the top combines with enable, i_mem_ready and i_zero.
    typedef struct packed {
        logic       fetch;
        logic       jump;
        logic       branch;
        logic       final_st;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_reg;
        logic       reg_dst;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t st, input logic [3:0] exec_alu);
        ctrl_t c;
        c         = '0;
        c.alu_ctl = ALU_ADD;
        c.pc_src  = PC_SRC_ALU;
        case (st)
            FETCH: begin
                c.fetch     = 1'b1;
                c.mem_rd    = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
            end
            DECODE: begin
                c.alu_src_b = SRC_B_OFFSET;
            end
            MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
            end
            MEMRD: begin
                c.mem_rd = 1'b1;
                c.i_or_d = 1'b1;
            end
            MEMWB: begin
                c.mem_reg  = 1'b1;
                c.reg_wr   = 1'b1;
                c.final_st = 1'b1;
            end
            MEMWR: begin
                c.mem_wr = 1'b1;
                c.i_or_d = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_ctl   = exec_alu;
            end
            ALUWB: begin
                c.reg_dst  = 1'b1;
                c.reg_wr   = 1'b1;
                c.final_st = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.alu_ctl   = ALU_SUB;
                c.pc_src    = PC_SRC_ALUOUT;
                c.branch    = 1'b1;
                c.final_st  = 1'b1;
            end
            ADDIEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_IMM;
            end
            ADDIWB: begin
                c.reg_wr   = 1'b1;
                c.final_st = 1'b1;
            end
            JUMP: begin
                c.pc_src   = PC_SRC_JUMP;
                c.jump     = 1'b1;
                c.final_st = 1'b1;
            end
            default: begin
                c.fetch = 1'b0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// mc_control_fsm_alu_decoder
// Maps an R-type funct field onto an ALU control code.
//   funct    : R-type funct field
//   alu_code : ALU control code (ADD when funct is not recognised)
//   valid    : 1 when funct is one of ADD/SUB/AND/OR/SLT
module mc_control_fsm_alu_decoder
    import mc_control_fsm_pkg::*;
#(
    parameter int FUNCT_WIDTH = 6
) (
    input  logic [FUNCT_WIDTH-1:0] funct,
    output logic [3:0]             alu_code,
    output logic                   valid
);

    always_comb begin
        alu_code = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            FUNCT_WIDTH'(FN_ADD): alu_code = ALU_ADD;
            FUNCT_WIDTH'(FN_SUB): alu_code = ALU_SUB;
            FUNCT_WIDTH'(FN_AND): alu_code = ALU_AND;
            FUNCT_WIDTH'(FN_OR):  alu_code = ALU_OR;
            FUNCT_WIDTH'(FN_SLT): alu_code = ALU_SLT;
            default:              valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multi-cycle processor control FSM (LW, SW, R-type, BEQ, BNE, ADDI, J).
// Inputs : i_clk, rst (async, active-high), enable (advance), i_opcode,
//          i_funct (both from the instruction register), i_zero, i_mem_ready.
// Outputs: pc_write, ir_write, i_or_d, MemRd, MemWr, MemReg, RegDst, RegWr,
//          alu_src_a, alu_src_b, o_alu_control, pc_src, instr_done,
//          illegal/fault (sticky until reset), o_state.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int OPCODE_WIDTH = 6,
    parameter int FUNCT_WIDTH  = 6,
    parameter int ALU_CONTROL  = 4,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                    i_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  i_funct,
    input  logic                    i_zero,
    input  logic                    i_mem_ready,
    output logic                    pc_write,
    output logic                    ir_write,
    output logic                    i_or_d,
    output logic                    MemRd,
    output logic                    MemWr,
    output logic                    MemReg,
    output logic                    RegDst,
    output logic                    RegWr,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALU_CONTROL-1:0]  o_alu_control,
    output logic [1:0]              pc_src,
    output logic                    instr_done,
    output logic                    illegal,
    output logic                    fault,
    output logic [3:0]              o_state
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             state;
    state_t             state_nxt;
    ctrl_t              ctrl_q;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_hit;
    logic               is_wait;
    logic               set_illegal;
    logic               set_fault;
    logic [3:0]         exec_alu;
    logic               exec_ok;
    logic               strobe_en;
    logic               branch_taken;

    mc_control_fsm_alu_decoder #(
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_alu_decoder (
        .funct    (i_funct),
        .alu_code (exec_alu),
        .valid    (exec_ok)
    );

    assign is_wait  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign wait_hit = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_nxt   = state;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        case (state)
            FETCH, MEMRD, MEMWR: begin
                // Ready wins over the timeout on the last allowed wait cycle.
                if (i_mem_ready) begin
                    if (state == FETCH)      state_nxt = DECODE;
                    else if (state == MEMRD) state_nxt = MEMWB;
                    else                     state_nxt = FETCH;
                end else if (wait_hit) begin
                    state_nxt = FAULT;
                    set_fault = 1'b1;
                end
            end
            DECODE: begin
                if (i_opcode == OPCODE_WIDTH'(OP_LW) || i_opcode == OPCODE_WIDTH'(OP_SW))
                    state_nxt = MEMADR;
                else if (i_opcode == OPCODE_WIDTH'(OP_RTYPE))
                    state_nxt = EXEC;
                else if (i_opcode == OPCODE_WIDTH'(OP_BEQ) || i_opcode == OPCODE_WIDTH'(OP_BNE))
                    state_nxt = BRANCH;
                else if (i_opcode == OPCODE_WIDTH'(OP_ADDI))
                    state_nxt = ADDIEXEC;
                else if (i_opcode == OPCODE_WIDTH'(OP_J))
                    state_nxt = JUMP;
                else begin
                    state_nxt   = FAULT;
                    set_illegal = 1'b1;
                end
            end
            MEMADR:   state_nxt = (i_opcode == OPCODE_WIDTH'(OP_SW)) ? MEMWR : MEMRD;
            EXEC: begin
                if (exec_ok) begin
                    state_nxt = ALUWB;
                end else begin
                    state_nxt   = FAULT;
                    set_illegal = 1'b1;
                end
            end
            ADDIEXEC: state_nxt = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_nxt = FETCH;
            FAULT:    state_nxt = FAULT;
            default: begin
                state_nxt = FAULT;
                set_fault = 1'b1;
            end
        endcase
    end

    // State, registered control vector, wait counter and sticky flags.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            ctrl_q   <= ctrl_for(FETCH, ALU_ADD);
            wait_cnt <= '0;
            illegal  <= 1'b0;
            fault    <= 1'b0;
        end else if (enable) begin
            state  <= state_nxt;
            ctrl_q <= ctrl_for(state_nxt, exec_alu);
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (is_wait)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (set_illegal) illegal <= 1'b1;
            if (set_fault)   fault   <= 1'b1;
        end
    end

    // Strobes only fire on cycles that actually advance the FSM; reset
    // suppresses them immediately even though ctrl_q already holds FETCH.
    assign strobe_en    = enable & ~rst;
    assign branch_taken = ((i_opcode == OPCODE_WIDTH'(OP_BEQ)) &  i_zero) |
                          ((i_opcode == OPCODE_WIDTH'(OP_BNE)) & ~i_zero);

    assign MemRd      = strobe_en & ctrl_q.mem_rd;
    assign MemWr      = strobe_en & ctrl_q.mem_wr;
    assign RegWr      = strobe_en & ctrl_q.reg_wr;
    assign ir_write   = strobe_en & ctrl_q.fetch & i_mem_ready;
    assign pc_write   = strobe_en & ((ctrl_q.fetch & i_mem_ready) | ctrl_q.jump |
                                     (ctrl_q.branch & branch_taken));
    assign instr_done = strobe_en & (ctrl_q.final_st | (ctrl_q.mem_wr & i_mem_ready));

    assign i_or_d        = ctrl_q.i_or_d;
    assign MemReg        = ctrl_q.mem_reg;
    assign RegDst        = ctrl_q.reg_dst;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign o_alu_control = ALU_CONTROL'(ctrl_q.alu_ctl);
    assign pc_src        = ctrl_q.pc_src;
    assign o_state       = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Drives whole instructions (fetch through write-back) with random memory
// stalls, random enable gaps and random don't-care inputs, and compares every
// cycle's outputs with the values expected for the current instruction phase.
module tb_mc_control_fsm;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [5:0] i_opcode;
    logic [5:0] i_funct;
    logic       i_zero;
    logic       i_mem_ready;
    logic       pc_write, ir_write, i_or_d, MemRd, MemWr, MemReg, RegDst, RegWr;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] o_alu_control;
    logic [1:0] pc_src;
    logic       instr_done, illegal, fault;
    logic [3:0] o_state;

    mc_control_fsm dut (
        .i_clk         (clk),
        .rst           (rst),
        .enable        (enable),
        .i_opcode      (i_opcode),
        .i_funct       (i_funct),
        .i_zero        (i_zero),
        .i_mem_ready   (i_mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .MemRd         (MemRd),
        .MemWr         (MemWr),
        .MemReg        (MemReg),
        .RegDst        (RegDst),
        .RegWr         (RegWr),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .o_alu_control (o_alu_control),
        .pc_src        (pc_src),
        .instr_done    (instr_done),
        .illegal       (illegal),
        .fault         (fault),
        .o_state       (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // State indices in the order the states are listed.
    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                   S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEXEC = 9,
                   S_ADDIWB = 10, S_JUMP = 11, S_FAULT = 12;
    localparam int TIMEOUT = 15;

    // Bit positions in the observed-output word.
    localparam int P_FLT = 0, P_ILL = 1, P_DONE = 2, P_PCSRC = 3, P_ALU = 5, P_SRCB = 9,
                   P_SRCA = 11, P_REGWR = 12, P_REGDST = 13, P_MEMREG = 14, P_MEMWR = 15,
                   P_MEMRD = 16, P_IORD = 17, P_IRW = 18, P_PCW = 19, P_STATE = 20;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [23:0] exp_v, exp_m;
    logic        ill_m, flt_m;
    int          rand_holds;

    task automatic check_val(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    endtask

    function automatic logic [23:0] observed();
        return {o_state, pc_write, ir_write, i_or_d, MemRd, MemWr, MemReg, RegDst, RegWr,
                alu_src_a, alu_src_b, o_alu_control, pc_src, instr_done, illegal, fault};
    endfunction

    function automatic string st_name(input int st);
        case (st)
            S_FETCH: return "FETCH";     S_DECODE: return "DECODE";
            S_MEMADR: return "MEMADR";   S_MEMRD: return "MEMRD";
            S_MEMWB: return "MEMWB";     S_MEMWR: return "MEMWR";
            S_EXEC: return "EXEC";       S_ALUWB: return "ALUWB";
            S_BRANCH: return "BRANCH";   S_ADDIEXEC: return "ADDIEXEC";
            S_ADDIWB: return "ADDIWB";   S_JUMP: return "JUMP";
            default: return "FAULT";
        endcase
    endfunction

    // {known, code} for the R-type funct table.
    function automatic logic [4:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, 4'b0010};
            6'b100010: return {1'b1, 4'b0110};
            6'b100100: return {1'b1, 4'b0000};
            6'b100101: return {1'b1, 4'b0001};
            6'b101010: return {1'b1, 4'b0111};
            default:   return 5'b0;
        endcase
    endfunction

    task automatic want(input int pos, input int w, input int val);
        for (int b = 0; b < w; b++) begin
            exp_m[pos+b] = 1'b1;
            exp_v[pos+b] = val[b];
        end
    endtask

    // Expected outputs for one cycle spent in state st.
    task automatic expect_in(input int st, input logic rdy, input logic en);
        logic [4:0] r;
        logic       taken;
        exp_m = '0;
        exp_v = '0;
        want(P_STATE, 4, st);
        want(P_ILL, 1, int'(ill_m));
        want(P_FLT, 1, int'(flt_m));
        want(P_PCW, 1, 0);  want(P_IRW, 1, 0);   want(P_MEMRD, 1, 0);
        want(P_MEMWR, 1, 0); want(P_REGWR, 1, 0); want(P_DONE, 1, 0);
        if (!en) return;
        case (st)
            S_FETCH: begin
                want(P_MEMRD, 1, 1); want(P_IORD, 1, 0);
                want(P_IRW, 1, int'(rdy)); want(P_PCW, 1, int'(rdy));
                want(P_SRCA, 1, 0); want(P_SRCB, 2, 1); want(P_ALU, 4, 2); want(P_PCSRC, 2, 0);
            end
            S_DECODE: begin
                want(P_SRCA, 1, 0); want(P_SRCB, 2, 3); want(P_ALU, 4, 2);
            end
            S_MEMADR, S_ADDIEXEC: begin
                want(P_SRCA, 1, 1); want(P_SRCB, 2, 2); want(P_ALU, 4, 2);
            end
            S_MEMRD: begin
                want(P_MEMRD, 1, 1); want(P_IORD, 1, 1);
            end
            S_MEMWB: begin
                want(P_REGDST, 1, 0); want(P_MEMREG, 1, 1); want(P_REGWR, 1, 1); want(P_DONE, 1, 1);
            end
            S_MEMWR: begin
                want(P_MEMWR, 1, 1); want(P_IORD, 1, 1); want(P_DONE, 1, int'(rdy));
            end
            S_EXEC: begin
                r = ref_alu(i_funct);
                want(P_SRCA, 1, 1); want(P_SRCB, 2, 0);
                if (r[4]) want(P_ALU, 4, int'(r[3:0]));
            end
            S_ALUWB: begin
                want(P_REGDST, 1, 1); want(P_MEMREG, 1, 0); want(P_REGWR, 1, 1); want(P_DONE, 1, 1);
            end
            S_BRANCH: begin
                taken = ((i_opcode == 6'b000100) && i_zero) || ((i_opcode == 6'b000101) && !i_zero);
                want(P_SRCA, 1, 1); want(P_SRCB, 2, 0); want(P_ALU, 4, 6); want(P_PCSRC, 2, 1);
                want(P_PCW, 1, int'(taken)); want(P_DONE, 1, 1);
            end
            S_ADDIWB: begin
                want(P_REGDST, 1, 0); want(P_MEMREG, 1, 0); want(P_REGWR, 1, 1); want(P_DONE, 1, 1);
            end
            S_JUMP: begin
                want(P_PCSRC, 2, 2); want(P_PCW, 1, 1); want(P_DONE, 1, 1);
            end
            default: ;
        endcase
    endtask

    task automatic step(input logic en, input logic rdy, input string tag);
        enable      = en;
        i_mem_ready = rdy;
        @(negedge clk);
        check_val(tag, observed() & exp_m, exp_v & exp_m);
        @(posedge clk);
        #1;
    endtask

    // Disabled cycles: state frozen, strobes low, ready must be ignored.
    task automatic holds(input int st, input int n);
        logic r;
        for (int h = 0; h < n; h++) begin
            r = 1'($urandom_range(0, 1));
            expect_in(st, r, 1'b0);
            step(1'b0, r, {st_name(st), "_hold"});
        end
    endtask

    function automatic int rand_gap();
        if (rand_holds != 0 && $urandom_range(0, 4) == 0) return 1 + $urandom_range(0, 1);
        return 0;
    endfunction

    // One state visit: 'waits' not-ready cycles then ready (wait states only).
    task automatic phase(input int st, input int waits, input int hold);
        logic rdy;
        bit   is_wait;
        is_wait = (st == S_FETCH) || (st == S_MEMRD) || (st == S_MEMWR);
        for (int k = 0; k <= waits; k++) begin
            holds(st, ((k == 0) ? hold : 0) + rand_gap());
            rdy = is_wait ? (k == waits) : 1'($urandom_range(0, 1));
            expect_in(st, rdy, 1'b1);
            step(1'b1, rdy, st_name(st));
        end
    endtask

    task automatic apply_reset();
        rst         = 1'b1;
        enable      = 1'($urandom_range(0, 1));
        i_mem_ready = 1'($urandom_range(0, 1));
        ill_m = 1'b0;
        flt_m = 1'b0;
        exp_m = '0;
        exp_v = '0;
        want(P_STATE, 4, S_FETCH);
        want(P_PCW, 1, 0); want(P_IRW, 1, 0); want(P_MEMRD, 1, 0); want(P_MEMWR, 1, 0);
        want(P_REGWR, 1, 0); want(P_DONE, 1, 0); want(P_ILL, 1, 0); want(P_FLT, 1, 0);
        want(P_ALU, 4, 2); want(P_PCSRC, 2, 0);
        @(negedge clk);
        check_val("reset", observed() & exp_m, exp_v & exp_m);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fault_hold();
        logic e, r;
        for (int i = 0; i < 3; i++) begin
            e = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            expect_in(S_FAULT, r, e);
            step(e, r, "FAULT");
        end
        apply_reset();
    endtask

    task automatic timeout_in(input int st);
        for (int k = 0; k < TIMEOUT; k++) begin
            holds(st, rand_gap());
            expect_in(st, 1'b0, 1'b1);
            step(1'b1, 1'b0, {st_name(st), "_wait"});
        end
        flt_m = 1'b1;
        fault_hold();
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input bit mem_to, input int mem_waits);
        i_opcode = 6'($urandom);
        i_funct  = 6'($urandom);
        i_zero   = 1'($urandom_range(0, 1));
        phase(S_FETCH, $urandom_range(0, 3), 0);
        i_opcode = op;
        i_funct  = fn;
        i_zero   = z;
        phase(S_DECODE, 0, 0);
        case (op)
            6'b100011: begin
                phase(S_MEMADR, 0, 0);
                if (mem_to) timeout_in(S_MEMRD);
                else begin
                    phase(S_MEMRD, mem_waits, 0);
                    phase(S_MEMWB, 0, 0);
                end
            end
            6'b101011: begin
                phase(S_MEMADR, 0, 0);
                if (mem_to) timeout_in(S_MEMWR);
                else phase(S_MEMWR, mem_waits, 0);
            end
            6'b000000: begin
                phase(S_EXEC, 0, 0);
                if (ref_alu(fn) != 5'b0) phase(S_ALUWB, 0, 0);
                else begin
                    ill_m = 1'b1;
                    fault_hold();
                end
            end
            6'b000100, 6'b000101: phase(S_BRANCH, 0, 0);
            6'b001000: begin
                phase(S_ADDIEXEC, 0, 0);
                phase(S_ADDIWB, 0, 0);
            end
            6'b000010: phase(S_JUMP, 0, 0);
            default: begin
                ill_m = 1'b1;
                fault_hold();
            end
        endcase
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d expected completion", n_checks);
        $fatal(1);
    end

    localparam logic [5:0] OPS [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                       6'b000101, 6'b001000, 6'b000010};
    localparam logic [5:0] FNS [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] op, fn;
        rst = 1'b1; enable = 1'b0; i_opcode = '0; i_funct = '0; i_zero = 1'b0; i_mem_ready = 1'b0;
        ill_m = 1'b0; flt_m = 1'b0; rand_holds = 0;
        @(posedge clk);
        #1;
        apply_reset();

        // Directed: R-type ADD, LW with 3 stalls, BEQ/BNE with zero set.
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);
        // Illegal opcode, unknown funct.
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
        // Ready on the last allowed MEMRD wait cycle still completes.
        run_instr(6'b100011, 6'b000000, 1'b0, 0, TIMEOUT - 1);
        // Fetch timeout.
        i_opcode = 6'($urandom);
        timeout_in(S_FETCH);

        // Reset in the middle of a store, then a clean R-type.
        phase(S_FETCH, 0, 0);
        i_opcode = 6'b101011;
        phase(S_DECODE, 0, 0);
        phase(S_MEMADR, 0, 0);
        expect_in(S_MEMWR, 1'b0, 1'b1);
        step(1'b1, 1'b0, "MEMWR_pre_reset");
        apply_reset();
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);

        // Four disabled cycles while in EXEC.
        phase(S_FETCH, 0, 0);
        i_opcode = 6'b000000;
        i_funct  = 6'b101010;
        phase(S_DECODE, 0, 0);
        phase(S_EXEC, 0, 4);
        phase(S_ALUWB, 0, 0);

        // Random instruction stream with enable gaps.
        rand_holds = 1;
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : FNS[$urandom_range(0, 4)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                      $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
